alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the operand and result width.
REQ-002 Parameter OPCODE_LENGTH, default 4, SHALL set the ALU operation code width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 req0_valid / req1_valid  input  1 each  SHALL mean requester 0 / 1 presents an operation.
REQ-006 req0_ready / req1_ready  output  1 each  SHALL mean the arbiter accepts that requester's operation this cycle.
REQ-007 req0_srca, req0_srcb, req1_srca, req1_srcb  input  DATA_WIDTH each  SHALL carry the operands.
REQ-008 req0_op / req1_op  input  OPCODE_LENGTH each  SHALL carry the ALU operation code.
REQ-009 rsp_valid  output  1  SHALL mean rsp_result and rsp_id hold a completed result.
REQ-010 rsp_ready  input  1  SHALL mean the consumer takes the response this cycle.
REQ-011 rsp_id  output  1  SHALL identify the requester that owns the response (0 or 1).
REQ-012 rsp_result  output  DATA_WIDTH  SHALL carry the ALU result.

Function
REQ-013 The block SHALL share one ALU instance between two requesters through a 3-state FSM: IDLE, EXEC, RESP.
REQ-014 In IDLE with at least one reqN_valid high, the block SHALL grant exactly one requester, drive its reqN_ready high combinationally in that cycle, latch its srca/srcb/op and id, and move to EXEC.
REQ-015 req0_ready and req1_ready SHALL be low in EXEC and RESP, and never high together.
REQ-016 Arbitration SHALL be round-robin.
  - If both requesters are valid, the grant goes to the requester not granted last.
  - If only one is valid, it is granted regardless of history.
REQ-017 In EXEC, the ALU SHALL evaluate the latched operands, and the block SHALL register the result into rsp_result, set rsp_valid, and move to RESP.
REQ-018 In RESP, rsp_valid, rsp_id and rsp_result SHALL hold stable until a cycle with rsp_valid and rsp_ready both high; the block SHALL then return to IDLE with rsp_valid low.
REQ-019 Latency SHALL be fixed: accept at edge N leads to rsp_valid high after edge N+2.
REQ-020 Throughput SHALL be at most one operation per 3 cycles; no new request SHALL be accepted in the handshake cycle of RESP.
REQ-021 Opcodes the ALU does not support (anything other than AND 0000, OR 0001, ADD 0010, SUB 0011, XOR 0110, EQ 1000) SHALL produce result 0 and still complete normally.
REQ-022 ADD and SUB SHALL wrap modulo 2^DATA_WIDTH with no carry or overflow output.
REQ-023 A requester that drops valid before being granted SHALL lose no state; a grant depends only on the valid signals sampled in that IDLE cycle.
REQ-024 The last-grant pointer SHALL update only on acceptance, not on response.

Reset
REQ-025 Reset SHALL force state IDLE, rsp_valid 0, rsp_id 0, rsp_result 0, latched operands and op 0, and last-grant 1, so requester 0 wins the first contention.
REQ-026 Reset asserted in EXEC or RESP SHALL discard the in-flight operation with no response emitted; reqN_ready SHALL be 0 while reset is high.

Structure
REQ-027 The ALU opcode constants (AND, OR, ADD, SUB, XOR, EQ) and an FSM state enum SHALL reside in a shared package, alu_pkg, imported by this block and the ALU.
REQ-028 The block SHALL instantiate the existing alu module as its only sub-module, with parameters DATA_WIDTH and OPCODE_LENGTH passed through.
REQ-029 The block SHALL contain no other arithmetic; all computation goes through the alu instance.

Verification
REQ-030 Single request: req0 valid with ADD 5 + 7 and rsp_ready held high -> req0_ready high in cycle 0; rsp_valid high in cycle 2 with rsp_id 0, rsp_result 12.
REQ-031 Contention after reset: both requesters valid continuously (req0 SUB 10-3, req1 XOR 0xF0^0x0F), rsp_ready=1 -> grants alternate 0,1,0,1; results 7 with id 0 and 0xFF with id 1.
REQ-032 Backpressure: rsp_ready low for 5 cycles during RESP -> rsp_valid, rsp_id and rsp_result stable for all 5 cycles; both reqN_ready low; completion in the cycle rsp_ready rises.
REQ-033 Edge ops: ADD 0xFFFFFFFF+1 -> 0; EQ 9,9 -> 1; EQ 9,8 -> 0; op 0101 -> 0.
REQ-034 Reset mid-operation: reset pulsed in EXEC -> no rsp_valid afterwards; the next contention grants requester 0.
REQ-035 Random stimulus with a scoreboard: every accepted request SHALL yield exactly one response with the matching id and result, in acceptance order.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU opcode encodings and the arbiter FSM state type.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0110;
  localparam logic [3:0] ALU_EQ  = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/alu.sv
// Combinational ALU; unsupported opcodes yield zero, ADD/SUB wrap silently.
module alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic [DATA_WIDTH-1:0]    srca_i,
  input  logic [DATA_WIDTH-1:0]    srcb_i,
  input  logic [OPCODE_LENGTH-1:0] op_i,
  output logic [DATA_WIDTH-1:0]    result_o
);

  always_comb begin
    result_o = '0;
    case (op_i)
      OPCODE_LENGTH'(ALU_AND): result_o = srca_i & srcb_i;
      OPCODE_LENGTH'(ALU_OR):  result_o = srca_i | srcb_i;
      OPCODE_LENGTH'(ALU_ADD): result_o = srca_i + srcb_i;
      OPCODE_LENGTH'(ALU_SUB): result_o = srca_i - srcb_i;
      OPCODE_LENGTH'(ALU_XOR): result_o = srca_i ^ srcb_i;
      OPCODE_LENGTH'(ALU_EQ):  result_o = DATA_WIDTH'(srca_i == srcb_i);
      default:                 result_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters via an
// IDLE -> EXEC -> RESP handshake FSM.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [DATA_WIDTH-1:0]    req0_srca,
  input  logic [DATA_WIDTH-1:0]    req0_srcb,
  input  logic [OPCODE_LENGTH-1:0] req0_op,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [DATA_WIDTH-1:0]    req1_srca,
  input  logic [DATA_WIDTH-1:0]    req1_srcb,
  input  logic [OPCODE_LENGTH-1:0] req1_op,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_id,
  output logic [DATA_WIDTH-1:0]    rsp_result
);

  arb_state_e                state_q, state_d;
  logic                      last_q, last_d;
  logic                      id_q, id_d;
  logic [DATA_WIDTH-1:0]     srca_q, srca_d;
  logic [DATA_WIDTH-1:0]     srcb_q, srcb_d;
  logic [OPCODE_LENGTH-1:0]  op_q, op_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic                      rsp_id_q, rsp_id_d;
  logic [DATA_WIDTH-1:0]     rsp_result_q, rsp_result_d;
  logic [DATA_WIDTH-1:0]     alu_result;
  logic                      any_valid;
  logic                      grant1;

  alu #(
    .DATA_WIDTH    (DATA_WIDTH),
    .OPCODE_LENGTH (OPCODE_LENGTH)
  ) u_alu (
    .srca_i   (srca_q),
    .srcb_i   (srcb_q),
    .op_i     (op_q),
    .result_o (alu_result)
  );

  // Requester 1 wins when it is alone, or on contention if 0 was granted last.
  assign any_valid = req0_valid | req1_valid;
  assign grant1    = req1_valid & (~req0_valid | ~last_q);

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    id_d         = id_q;
    srca_d       = srca_q;
    srcb_d       = srcb_q;
    op_d         = op_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_valid && !reset) begin
          req0_ready = ~grant1;
          req1_ready = grant1;
          id_d       = grant1;
          last_d     = grant1;
          srca_d     = grant1 ? req1_srca : req0_srca;
          srcb_d     = grant1 ? req1_srcb : req0_srcb;
          op_d       = grant1 ? req1_op   : req0_op;
          state_d    = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_result_d = alu_result;
        rsp_id_d     = id_q;
        rsp_valid_d  = 1'b1;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_q       <= 1'b1;
      id_q         <= 1'b0;
      srca_q       <= '0;
      srcb_q       <= '0;
      op_q         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      id_q         <= id_d;
      srca_q       <= srca_d;
      srcb_q       <= srcb_d;
      op_q         <= op_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and scoreboard-checked stimulus for alu_arbiter.
module tb_alu_arbiter;

  logic        clk;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_srca, req0_srcb, req1_srca, req1_srcb;
  logic [3:0]  req0_op, req1_op;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_result;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic        id;
    logic [31:0] res;
  } exp_t;
  exp_t sb_q[$];

  alu_arbiter #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_srca  (req0_srca),
    .req0_srcb  (req0_srcb),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_srca  (req1_srca),
    .req1_srcb  (req1_srcb),
    .req1_op    (req1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0011: return a - b;
      4'b0110: return a ^ b;
      4'b1000: return (a == b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    cyc();
    reset = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    cyc();
    reset = 1'b0;
  endtask

  task automatic do_single(input string tag, input logic id, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    cyc();
    rsp_ready = 1'b1;
    if (id) begin
      req1_valid = 1'b1; req1_op = op; req1_srca = a; req1_srcb = b;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_srca = a; req0_srcb = b;
    end
    @(negedge clk);
    chk({tag, "_rdy0"}, 32'(req0_ready), 32'(!id));
    chk({tag, "_rdy1"}, 32'(req1_ready), 32'(id));
    cyc();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_exec_vld"}, 32'(rsp_valid), 32'd0);
    cyc();
    @(negedge clk);
    chk({tag, "_vld"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_id"}, 32'(rsp_id), 32'(id));
    chk({tag, "_res"}, rsp_result, exp);
  endtask

  task automatic sb_check_rsp();
    exp_t e;
    if (rsp_valid && rsp_ready) begin
      chk("sb_expected", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("sb_id", 32'(rsp_id), 32'(e.id));
        chk("sb_res", rsp_result, e.res);
      end
    end
  endtask

  initial begin
    logic [3:0] ops [7];
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0110, 4'b1000, 4'b1111};
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_srca = '0; req0_srcb = '0; req0_op = '0;
    req1_srca = '0; req1_srcb = '0; req1_op = '0;
    rsp_ready = 1'b1;

    // Reset state, readies held low while reset is high
    cyc();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    @(negedge clk);
    chk("rst_rdy0", 32'(req0_ready), 32'd0);
    chk("rst_rdy1", 32'(req1_ready), 32'd0);
    chk("rst_vld", 32'(rsp_valid), 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    chk("rst_res", rsp_result, 32'd0);
    cyc();
    reset = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    do_single("add", 1'b0, 4'b0010, 32'd5, 32'd7, 32'd12);

    // Contention right after reset: grants 0,1,0,1
    pulse_reset();
    for (int k = 0; k < 12; k++) begin
      cyc();
      if (k == 0) begin
        req0_valid = 1'b1; req0_op = 4'b0011; req0_srca = 32'd10; req0_srcb = 32'd3;
        req1_valid = 1'b1; req1_op = 4'b0110; req1_srca = 32'hF0; req1_srcb = 32'h0F;
      end
      @(negedge clk);
      case (k % 3)
        0: begin
          chk("cont_rdy0", 32'(req0_ready), 32'(((k / 3) % 2) == 0));
          chk("cont_rdy1", 32'(req1_ready), 32'(((k / 3) % 2) == 1));
        end
        1: begin
          chk("cont_exec_rdy", 32'(req0_ready | req1_ready), 32'd0);
          chk("cont_exec_vld", 32'(rsp_valid), 32'd0);
        end
        default: begin
          chk("cont_vld", 32'(rsp_valid), 32'd1);
          chk("cont_id", 32'(rsp_id), 32'((k / 3) % 2));
          chk("cont_res", rsp_result, (((k / 3) % 2) == 1) ? 32'hFF : 32'd7);
        end
      endcase
    end
    cyc();
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Backpressure: response held for 5 stalled cycles, no acceptance meanwhile
    for (int k = 0; k < 11; k++) begin
      cyc();
      if (k == 0) begin
        req1_valid = 1'b1; req1_op = 4'b0000; req1_srca = 32'hF0F0; req1_srcb = 32'hFF00;
        rsp_ready = 1'b0;
      end else if (k == 1) begin
        req0_valid = 1'b1; req0_op = 4'b0001; req0_srca = 32'h0F; req0_srcb = 32'hF0;
      end else if (k == 7) begin
        rsp_ready = 1'b1;
      end else if (k == 9) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      @(negedge clk);
      if (k == 0) begin
        chk("bp_rdy1", 32'(req1_ready), 32'd1);
      end else if (k >= 2 && k <= 7) begin
        chk("bp_vld", 32'(rsp_valid), 32'd1);
        chk("bp_id", 32'(rsp_id), 32'd1);
        chk("bp_res", rsp_result, 32'hF000);
        chk("bp_rdy", 32'(req0_ready | req1_ready), 32'd0);
      end else if (k == 8) begin
        chk("bp_done_vld", 32'(rsp_valid), 32'd0);
        chk("bp_next_rdy0", 32'(req0_ready), 32'd1);
        chk("bp_next_rdy1", 32'(req1_ready), 32'd0);
      end else if (k == 10) begin
        chk("bp_next_id", 32'(rsp_id), 32'd0);
        chk("bp_next_res", rsp_result, 32'hFF);
      end
    end

    do_single("add_wrap", 1'b0, 4'b0010, 32'hFFFFFFFF, 32'd1, 32'd0);
    do_single("eq_true", 1'b1, 4'b1000, 32'd9, 32'd9, 32'd1);
    do_single("eq_false", 1'b0, 4'b1000, 32'd9, 32'd8, 32'd0);
    do_single("bad_op", 1'b1, 4'b0101, 32'd3, 32'd5, 32'd0);
    do_single("sub_wrap", 1'b0, 4'b0011, 32'd3, 32'd5, 32'hFFFFFFFE);

    // Reset pulsed during EXEC discards the operation
    for (int k = 0; k < 7; k++) begin
      cyc();
      if (k == 0) begin
        req1_valid = 1'b1; req1_op = 4'b0011; req1_srca = 32'd9; req1_srcb = 32'd4;
      end else if (k == 1) begin
        reset = 1'b1; req1_valid = 1'b0; req0_valid = 1'b1;
      end else if (k == 2) begin
        reset = 1'b0; req0_valid = 1'b0;
      end else if (k == 4) begin
        req0_valid = 1'b1; req0_op = 4'b0010; req0_srca = 32'd1; req0_srcb = 32'd2;
        req1_valid = 1'b1; req1_op = 4'b0110; req1_srca = 32'd1; req1_srcb = 32'd2;
      end else if (k == 5) begin
        req0_valid = 1'b0; req1_valid = 1'b0;
      end
      @(negedge clk);
      if (k == 0) chk("mid_rdy1", 32'(req1_ready), 32'd1);
      if (k == 1) chk("mid_rst_rdy0", 32'(req0_ready), 32'd0);
      if (k >= 1 && k <= 3) chk("mid_no_rsp", 32'(rsp_valid), 32'd0);
      if (k == 4) begin
        chk("mid_next_rdy0", 32'(req0_ready), 32'd1);
        chk("mid_next_rdy1", 32'(req1_ready), 32'd0);
      end
      if (k == 6) begin
        chk("mid_next_id", 32'(rsp_id), 32'd0);
        chk("mid_next_res", rsp_result, 32'd3);
      end
    end

    // Random traffic against a scoreboard
    for (int k = 0; k < 300; k++) begin
      cyc();
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      rsp_ready  = 1'($urandom_range(0, 1));
      req0_op    = ops[$urandom_range(0, 6)];
      req1_op    = ops[$urandom_range(0, 6)];
      req0_srca  = $urandom;
      req1_srca  = $urandom;
      req0_srcb  = ($urandom_range(0, 3) == 0) ? req0_srca : $urandom;
      req1_srcb  = ($urandom_range(0, 3) == 0) ? req1_srca : $urandom;
      @(negedge clk);
      chk("rnd_excl", 32'(req0_ready & req1_ready), 32'd0);
      if (req0_ready) sb_q.push_back('{id: 1'b0, res: model(req0_op, req0_srca, req0_srcb)});
      if (req1_ready) sb_q.push_back('{id: 1'b1, res: model(req1_op, req1_srca, req1_srcb)});
      sb_check_rsp();
    end
    for (int k = 0; k < 6; k++) begin
      cyc();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rsp_ready  = 1'b1;
      @(negedge clk);
      sb_check_rsp();
    end
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
